// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
//   REG_ADDR_W / REG_DATA_W : default register address / data widths
//   arb_state_e             : arbiter FSM state (IDLE, LOCKED)
//   reg_addr_t / reg_data_t : register address / data at default widths
package regfile_arb_pkg;

  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned REG_DATA_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : index of the last winner; search starts at ptr+1 and wraps
//   grant_c : one-hot grant (zero when no request)
//   idx_c   : index of the granted request
//   any_c   : at least one request present
module rr_arb_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  logic             hi_any;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Lowest request above ptr wins; otherwise wrap to the lowest request overall.
  always_comb begin
    hi_any = 1'b0;
    hi_idx = '0;
    any_c  = 1'b0;
    lo_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_c  = 1'b1;
        lo_idx = IDX_W'(i);
        if (IDX_W'(i) > ptr) begin
          hi_any = 1'b1;
          hi_idx = IDX_W'(i);
        end
      end
    end
    idx_c   = hi_any ? hi_idx : lo_idx;
    grant_c = any_c ? (N'(1) << idx_c) : '0;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ requesters,
// with optional burst lock (up to MAX_BURST consecutive beats per ownership).
//   clk_i, RES_ni       : clock (rising edge), async active-low reset
//   req_valid_i/lock_i  : per-requester write valid / keep-ownership request
//   req_dest_i/data_i   : per-requester destination / data, requester i at slice i
//   req_ready_o         : one-hot (or zero) combinational grant
//   WRT_EN/DEST/DATA_o  : registered regfile write, one cycle after acceptance
//   owner_o, locked_o   : current/last owner, high while in LOCKED
//   grant_cnt_o         : per-requester saturating beat counters (REGARB_STATS_EN only)
module regfile_wr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_W    = regfile_arb_pkg::REG_ADDR_W,
  parameter int unsigned DATA_W    = regfile_arb_pkg::REG_DATA_W,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned OWN_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      RES_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_lock_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_dest_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      WRT_EN_o,
  output logic [ADDR_W-1:0]         WRT_DEST_o,
  output logic [DATA_W-1:0]         WRT_DATA_o,
  output logic [OWN_W-1:0]          owner_o,
  output logic                      locked_o
`ifdef REGARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0]  grant_cnt_o
`endif
);

  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

  arb_state_e         state_q, state_d;
  logic [OWN_W-1:0]   owner_q, owner_d;   // also serves as the round-robin pointer
  logic [BURST_W-1:0] burst_q, burst_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [OWN_W-1:0]   pick_idx;
  logic               pick_any;

  logic [NUM_REQ-1:0] ready_c;
  logic               acc_c;
  logic [OWN_W-1:0]   acc_idx;
  logic [ADDR_W-1:0]  sel_dest;
  logic [DATA_W-1:0]  sel_data;

  rr_arb_pick #(
    .N     (NUM_REQ),
    .IDX_W (OWN_W)
  ) u_pick (
    .req     (req_valid_i),
    .ptr     (owner_q),
    .grant_c (pick_grant),
    .idx_c   (pick_idx),
    .any_c   (pick_any)
  );

  // State register
  always_ff @(posedge clk_i or negedge RES_ni) begin
    if (!RES_ni) begin
      state_q <= IDLE;
      owner_q <= OWN_W'(NUM_REQ - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
    end
  end

  // Next state, grant and accepted-beat selection
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    burst_d = burst_q;
    ready_c = '0;
    acc_c   = 1'b0;
    acc_idx = owner_q;
    case (state_q)
      IDLE: begin
        ready_c = pick_grant;
        if (pick_any) begin
          acc_c   = 1'b1;
          acc_idx = pick_idx;
          owner_d = pick_idx;
          burst_d = BURST_W'(1);
          if (req_lock_i[pick_idx] && (MAX_BURST > 1)) state_d = LOCKED;
        end
      end
      LOCKED: begin
        // Owner dropping valid releases the port with no grant this cycle.
        if (req_valid_i[owner_q]) begin
          ready_c = NUM_REQ'(1) << owner_q;
          acc_c   = 1'b1;
          if (req_lock_i[owner_q] && (burst_q < BURST_W'(MAX_BURST - 1))) begin
            burst_d = BURST_W'(burst_q + BURST_W'(1));
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // No handshake may complete while reset is held.
    if (!RES_ni) begin
      ready_c = '0;
      acc_c   = 1'b0;
    end
  end

  // Mux the accepted requester's payload
  always_comb begin
    sel_dest = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (OWN_W'(i) == acc_idx) begin
        sel_dest = req_dest_i[i*ADDR_W +: ADDR_W];
        sel_data = req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Write-port output register
  always_ff @(posedge clk_i or negedge RES_ni) begin
    if (!RES_ni) begin
      WRT_EN_o   <= 1'b0;
      WRT_DEST_o <= '0;
      WRT_DATA_o <= '0;
    end else begin
      WRT_EN_o <= acc_c;
      if (acc_c) begin
        WRT_DEST_o <= sel_dest;
        WRT_DATA_o <= sel_data;
      end
    end
  end

  assign req_ready_o = ready_c;
  assign owner_o     = owner_q;
  assign locked_o    = (state_q == LOCKED);

`ifdef REGARB_STATS_EN
  // Saturating accepted-beat counters
  always_ff @(posedge clk_i or negedge RES_ni) begin
    if (!RES_ni) begin
      grant_cnt_o <= '0;
    end else if (acc_c) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if ((OWN_W'(i) == acc_idx) && (grant_cnt_o[i] != 16'hFFFF)) begin
          grant_cnt_o[i] <= grant_cnt_o[i] + 16'd1;
        end
      end
    end
  end
`endif

endmodule
